// File: rtl/sopc_multi_timer.sv
// Multi-channel down-counting timer with per-channel prescaler, snapshot capture and
// sticky timeout interrupts, behind a 16-bit Avalon-style slave port.
module sopc_multi_timer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PRE_W          = 8,
  parameter int unsigned DEFAULT_PERIOD = 599
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam int unsigned HiW = CNT_W - 16;

  typedef enum logic [2:0] {
    RegStatus, RegControl, RegPeriodL, RegPeriodH, RegSnapL, RegSnapH, RegPrescale, RegGstat
  } reg_e;

  logic [CNT_W-1:0] period_q   [NUM_CH];
  logic [CNT_W-1:0] period_d   [NUM_CH];
  logic [CNT_W-1:0] cnt_q      [NUM_CH];
  logic [CNT_W-1:0] cnt_d      [NUM_CH];
  logic [CNT_W-1:0] snap_q     [NUM_CH];
  logic [CNT_W-1:0] snap_d     [NUM_CH];
  logic [PRE_W-1:0] prescale_q [NUM_CH];
  logic [PRE_W-1:0] prescale_d [NUM_CH];
  logic [PRE_W-1:0] pre_cnt_q  [NUM_CH];
  logic [PRE_W-1:0] pre_cnt_d  [NUM_CH];

  logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
  logic [NUM_CH-1:0] wr_ch, tick, tmo, gstat_clr;
  logic [15:0]       readdata_q, readdata_d;

  logic wr_en;
  logic [1:0] ch_addr;
  reg_e reg_sel;

  assign wr_en   = chipselect & ~write_n;
  assign ch_addr = address[4:3];
  assign reg_sel = reg_e'(address[2:0]);

  always_comb begin
    wr_ch = '0;
    tick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch[i] = wr_en && (ch_addr == 2'(i));
      tick[i]  = run_q[i] && (pre_cnt_q[i] == prescale_q[i]);
    end
  end

  // GSTAT is mirrored in every implemented channel slot; out-of-range slots ignore writes.
  assign gstat_clr = ((|wr_ch) && (reg_sel == RegGstat)) ? writedata[NUM_CH-1:0] : '0;

  always_comb begin
    run_d  = run_q;
    to_d   = to_q;
    cont_d = cont_q;
    ito_d  = ito_q;
    tmo    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i]   = period_q[i];
      cnt_d[i]      = cnt_q[i];
      snap_d[i]     = snap_q[i];
      prescale_d[i] = prescale_q[i];
      pre_cnt_d[i]  = pre_cnt_q[i];

      if (run_q[i]) begin
        pre_cnt_d[i] = tick[i] ? '0 : pre_cnt_q[i] + PRE_W'(1);
      end
      if (tick[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = period_q[i];
          tmo[i]   = 1'b1;
          if (!cont_q[i]) run_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      if (wr_ch[i]) begin
        case (reg_sel)
          RegControl: begin
            cont_d[i] = writedata[1];
            ito_d[i]  = writedata[0];
            if (writedata[3]) begin
              run_d[i] = 1'b0;
            end else if (writedata[2]) begin
              run_d[i]     = 1'b1;
              pre_cnt_d[i] = '0;
            end
          end
          RegPeriodL, RegPeriodH: begin
            if (reg_sel == RegPeriodL) period_d[i][15:0] = writedata;
            else                       period_d[i][CNT_W-1:16] = writedata[HiW-1:0];
            // A period write re-arms the channel stopped; it overrides any tick this cycle.
            cnt_d[i]     = period_d[i];
            run_d[i]     = 1'b0;
            pre_cnt_d[i] = '0;
            tmo[i]       = 1'b0;
          end
          RegSnapL, RegSnapH: snap_d[i] = cnt_q[i];
          RegPrescale: begin
            prescale_d[i] = writedata[PRE_W-1:0];
            pre_cnt_d[i]  = '0;
            cnt_d[i]      = cnt_q[i];
            run_d[i]      = run_q[i];
            tmo[i]        = 1'b0;
          end
          default: ;
        endcase
      end

      if (tmo[i]) begin
        to_d[i] = 1'b1;
      end else if ((wr_ch[i] && (reg_sel == RegStatus)) || gstat_clr[i]) begin
        to_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_addr == 2'(i)) begin
        case (reg_sel)
          RegStatus:   readdata_d[1:0] = {run_q[i], to_q[i]};
          RegControl:  readdata_d[1:0] = {cont_q[i], ito_q[i]};
          RegPeriodL:  readdata_d = period_q[i][15:0];
          RegPeriodH:  readdata_d[HiW-1:0] = period_q[i][CNT_W-1:16];
          RegSnapL:    readdata_d = snap_q[i][15:0];
          RegSnapH:    readdata_d[HiW-1:0] = snap_q[i][CNT_W-1:16];
          RegPrescale: readdata_d[PRE_W-1:0] = prescale_q[i];
          RegGstat:    readdata_d[NUM_CH-1:0] = to_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]   <= CNT_W'(DEFAULT_PERIOD);
        cnt_q[i]      <= CNT_W'(DEFAULT_PERIOD);
        snap_q[i]     <= '0;
        prescale_q[i] <= '0;
        pre_cnt_q[i]  <= '0;
      end
      run_q      <= '0;
      to_q       <= '0;
      cont_q     <= '0;
      ito_q      <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]   <= period_d[i];
        cnt_q[i]      <= cnt_d[i];
        snap_q[i]     <= snap_d[i];
        prescale_q[i] <= prescale_d[i];
        pre_cnt_q[i]  <= pre_cnt_d[i];
      end
      run_q  <= run_d;
      to_q   <= to_d;
      cont_q <= cont_d;
      ito_q  <= ito_d;
      if (chipselect) readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_sopc_multi_timer.sv
// Bench for sopc_multi_timer: directed scenarios plus randomized channel setups, checked
// against an arithmetic model of timeout edges derived from start edge, period and prescale.
module tb_sopc_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [3:0]  irq_vec;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Per-channel model: start edge, period, prescale, last clear edge, mode bits.
  int unsigned n_m [4];
  int unsigned p_m [4];
  int unsigned s_m [4];
  int unsigned c_m [4];
  bit cont_m [4];
  bit ito_m [4];
  bit live [4];
  bit frozen_to [4];

  sopc_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [4:0] addr(input int ch, input int r);
    logic [4:0] a;
    a = 5'(ch * 8 + r);
    return a;
  endfunction

  // Timeout edges are S + m*(N+1)*(P+1); one-shot channels only have m = 1.
  function automatic bit m_to(input int ch, input int unsigned e);
    int unsigned t, lo, m;
    if (!live[ch]) return frozen_to[ch];
    t  = (n_m[ch] + 1) * (p_m[ch] + 1);
    lo = (c_m[ch] > s_m[ch]) ? c_m[ch] : s_m[ch] + 1;
    m  = (lo - s_m[ch] + t - 1) / t;
    if (m == 0) m = 1;
    if (!cont_m[ch] && m > 1) return 1'b0;
    return (s_m[ch] + m * t <= e);
  endfunction

  function automatic bit m_run(input int ch, input int unsigned e);
    if (!live[ch]) return 1'b0;
    return cont_m[ch] || (e < s_m[ch] + (n_m[ch] + 1) * (p_m[ch] + 1));
  endfunction

  function automatic logic [31:0] m_cnt(input int ch, input int unsigned e);
    int unsigned k;
    if (!cont_m[ch] && (e >= s_m[ch] + (n_m[ch] + 1) * (p_m[ch] + 1))) return n_m[ch];
    k = (e - s_m[ch]) / (p_m[ch] + 1);
    return n_m[ch] - (k % (n_m[ch] + 1));
  endfunction

  function automatic logic [3:0] exp_irq(input int unsigned e);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_to(c, e) & ito_m[c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d, output int unsigned e);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    e = cyc + 1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [15:0] d, output int unsigned e);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
    logic [15:0] d;
    int unsigned e;
    bus_read(a, d, e);
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic status_chk(input string tag, input int ch);
    logic [15:0] d;
    int unsigned e;
    bus_read(addr(ch, 0), d, e);
    chk(tag, 32'(d), 32'({m_run(ch, e - 1), m_to(ch, e - 1)}));
  endtask

  task automatic snap_chk(input string tag, input int ch);
    logic [15:0] d;
    logic [31:0] v;
    int unsigned e, w;
    bus_write(addr(ch, 4), 16'h0, w);
    v = m_cnt(ch, w - 1);
    bus_read(addr(ch, 4), d, e);
    chk({tag, "_l"}, 32'(d), 32'(v[15:0]));
    bus_read(addr(ch, 5), d, e);
    chk({tag, "_h"}, 32'(d), 32'(v[31:16]));
  endtask

  task automatic wait_chk(input int n);
    logic [3:0] ev;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ev = exp_irq(cyc);
      chk("irq_vec", 32'(irq_vec), 32'(ev));
      chk("irq", 32'(irq), 32'(|ev));
    end
  endtask

  task automatic setup_ch(input int ch, input int unsigned n, input int unsigned p,
                          input bit c, input bit it);
    int unsigned e;
    logic [15:0] w;
    live[ch] = 1'b0;
    frozen_to[ch] = 1'b0;
    bus_write(addr(ch, 3), n[31:16], e);
    bus_write(addr(ch, 2), n[15:0], e);
    bus_write(addr(ch, 6), p[15:0], e);
    bus_write(addr(ch, 0), 16'h0, e);
    w = 16'h0004 | {14'b0, c, it};
    bus_write(addr(ch, 1), w, e);
    n_m[ch] = n; p_m[ch] = p; cont_m[ch] = c; ito_m[ch] = it;
    s_m[ch] = e; c_m[ch] = 0; live[ch] = 1'b1;
  endtask

  initial begin
    int unsigned e, g;
    logic [15:0] d, mask;
    logic [3:0] ev;
    int ch;

    // Reset values while reset_n is held low.
    #1;
    chk("rst_readdata", 32'(readdata), 32'h0);
    chk("rst_irq_vec", 32'(irq_vec), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_chk("rst_period_l", addr(0, 2), 16'h0257);
    read_chk("rst_period_h", addr(1, 3), 16'h0000);
    read_chk("rst_status", addr(2, 0), 16'h0000);
    read_chk("rst_control", addr(3, 1), 16'h0000);
    read_chk("rst_prescale", addr(0, 6), 16'h0000);
    read_chk("rst_snap_l", addr(3, 4), 16'h0000);
    read_chk("rst_gstat", addr(1, 7), 16'h0000);

    // Continuous ch0, period 4: timeout every 5 cycles, STATUS write clears.
    setup_ch(0, 4, 0, 1'b1, 1'b1);
    wait_chk(12);
    read_chk("ch0_control", addr(0, 1), 16'h0003);
    bus_write(addr(0, 0), 16'h0, e);
    c_m[0] = e;
    wait_chk(8);

    // One-shot ch1: single timeout after 12 cycles, stops with counter reloaded.
    setup_ch(1, 2, 3, 1'b0, 1'b1);
    wait_chk(15);
    status_chk("ch1_status", 1);
    snap_chk("ch1_snap", 1);
    wait_chk(2);

    // Period write to a running channel reloads the counter and stops it.
    setup_ch(2, 32'h0001_0020, 0, 1'b1, 1'b0);
    wait_chk(5);
    bus_write(addr(2, 2), 16'h0010, e);
    frozen_to[2] = m_to(2, e - 1);
    live[2] = 1'b0;
    bus_write(addr(2, 4), 16'h0, e);
    read_chk("ch2_snap_l", addr(2, 4), 16'h0010);
    read_chk("ch2_snap_h", addr(2, 5), 16'h0001);
    status_chk("ch2_status", 2);
    wait_chk(3);

    // Snapshot of a running channel tracks the live counter.
    setup_ch(3, 1000, 1, 1'b1, 1'b1);
    wait_chk(7);
    snap_chk("ch3_snap_a", 3);
    wait_chk(9);
    snap_chk("ch3_snap_b", 3);

    // GSTAT selective clear and set-wins on a STATUS write.
    bus_write(addr(0, 1), 16'h0008, e);
    frozen_to[0] = m_to(0, e);
    live[0] = 1'b0;
    ito_m[0] = 1'b0;
    bus_write(addr(1, 0), 16'h0, e);
    c_m[1] = e;
    setup_ch(2, 3, 0, 1'b1, 1'b1);
    wait_chk(8);
    bus_write(addr(1, 7), 16'h0001, g);
    frozen_to[0] = 1'b0;
    bus_read(addr(3, 7), d, e);
    for (int c = 0; c < 4; c++) ev[c] = m_to(c, e - 1);
    chk("gstat_read", 32'(d), 32'(ev));
    status_chk("ch0_status_after_gstat", 0);
    for (int i = 0; i < 4 && (((cyc + 2 - s_m[2]) % 4) != 0); i++) @(negedge clk);
    bus_write(addr(2, 0), 16'h0, e);
    c_m[2] = e;
    status_chk("ch2_status_set_wins", 2);
    wait_chk(4);

    // Randomized channel setups, clears and snapshots.
    for (int it = 0; it < 8; it++) begin
      ch = int'($urandom_range(0, 3));
      setup_ch(ch, $urandom_range(0, 12), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_chk(int'($urandom_range(1, 30)));
      if ($urandom_range(0, 1) == 1) begin
        bus_write(addr(ch, 0), 16'h0, e);
        c_m[ch] = e;
      end else begin
        mask = 16'($urandom_range(0, 15));
        bus_write(addr(int'($urandom_range(0, 3)), 7), mask, e);
        for (int c = 0; c < 4; c++) begin
          if (mask[c]) begin
            if (live[c]) c_m[c] = e;
            else frozen_to[c] = 1'b0;
          end
        end
      end
      wait_chk(int'($urandom_range(1, 12)));
      snap_chk("rnd_snap", ch);
      status_chk("rnd_status", ch);
    end

    // Asynchronous reset mid-count.
    setup_ch(0, 4, 0, 1'b1, 1'b1);
    wait_chk(7);
    read_chk("pre_reset_period", addr(0, 2), 16'h0004);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      live[c] = 1'b0; frozen_to[c] = 1'b0; ito_m[c] = 1'b0;
    end
    #1;
    chk("async_rst_readdata", 32'(readdata), 32'h0);
    chk("async_rst_irq_vec", 32'(irq_vec), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_chk(10);
    read_chk("post_rst_period_l", addr(0, 2), 16'h0257);
    read_chk("post_rst_status", addr(0, 0), 16'h0000);
    bus_write(addr(0, 4), 16'h0, e);
    read_chk("post_rst_snap_a", addr(0, 4), 16'h0257);
    wait_chk(5);
    bus_write(addr(0, 5), 16'h0, e);
    read_chk("post_rst_snap_b", addr(0, 4), 16'h0257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
